// File: rtl/muldiv_seq.sv
// HI/LO multiply/divide sequencer: shift-add multiply, restoring divide, one bit per cycle.
// Latency WIDTH+1 cycles from acceptance to done_o; requests arriving while busy_o is high are dropped.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 is_mul_op, is_div_op, is_signed;
    logic                 a_neg, b_neg, div_zero;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum, rem_sh, rem_diff;
    logic [2*WIDTH-1:0]   mul_next, div_next, iter, prod;
    logic [WIDTH-1:0]     quo, rem;

    // Datapath for one iteration; the accumulator low half holds the
    // multiplier (multiply) or the dividend shifting into the quotient (divide).
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, mcand_q};
        div_next = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        iter     = is_div_q ? div_next : mul_next;
        prod     = neg_q ? -iter : iter;
        quo      = neg_q ? -iter[WIDTH-1:0] : iter[WIDTH-1:0];
        rem      = neg_rem_q ? -iter[2*WIDTH-1:WIDTH] : iter[2*WIDTH-1:WIDTH];
    end

    // Request decode and operand magnitudes. A zero divisor keeps the raw
    // dividend and no sign fix-up, so the plain iteration leaves lo=~0, hi=src1.
    always_comb begin
        is_mul_op = (funct_i == F_MULT) || (funct_i == F_MULTU);
        is_div_op = (funct_i == F_DIV)  || (funct_i == F_DIVU);
        is_signed = (funct_i == F_MULT) || (funct_i == F_DIV);
        div_zero  = is_div_op && (src2_i == '0);
        a_neg     = is_signed && src1_i[WIDTH-1] && !div_zero;
        b_neg     = is_signed && src2_i[WIDTH-1];
        a_mag     = a_neg ? -src1_i : src1_i;
        b_mag     = b_neg ? -src2_i : src2_i;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (funct_i == F_MTHI) begin
                        hi_d = src1_i;
                    end else if (funct_i == F_MTLO) begin
                        lo_d = src1_i;
                    end else if (is_mul_op || is_div_op) begin
                        is_div_d  = is_div_op;
                        neg_d     = a_neg ^ b_neg;
                        neg_rem_d = is_div_op && a_neg;
                        mcand_d   = is_div_op ? b_mag : a_mag;
                        acc_d     = {{WIDTH{1'b0}}, (is_div_op ? a_mag : b_mag)};
                        cnt_d     = CNT_W'(WIDTH);
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = iter;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
                    lo_d    = is_div_q ? quo : prod[WIDTH-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            mcand_q   <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // A reset landing in the DONE cycle suppresses the completion pulse.
    assign done_o = (state_q == DONE) && !rst_i;
    assign busy_o = (state_q != IDLE);
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: stimulus pushes expected {hi,lo} into a scoreboard,
// a negedge monitor pops and compares on every done_o pulse.
module tb_muldiv_seq;

    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [5:0]  funct_i = '0;
    logic [31:0] src1_i = '0;
    logic [31:0] src2_i = '0;
    logic        busy_o, done_o;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int failures = 0;
    logic [63:0] sb[$];

    muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .funct_i (funct_i),
        .src1_i  (src1_i),
        .src2_i  (src2_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every done_o must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (done_o) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0 hi=%h lo=%h", hi_o, lo_o);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("result_hi", {32'h0, hi_o}, {32'h0, e[63:32]});
                chk("result_lo", {32'h0, lo_o}, {32'h0, e[31:0]});
            end
        end
    end

    // Called at a negedge; the request is accepted on the next posedge and
    // the task returns at the first sample after acceptance.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        start_i = 1'b1;
        funct_i = f;
        src1_i  = a;
        src2_i  = b;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        chk("idle_timeout", {63'h0, busy_o}, 64'h0);
    endtask

    initial begin
        int busy_cnt;
        int done_at;

        repeat (3) @(negedge clk_i);
        chk("rst_busy", {63'h0, busy_o}, 64'h0);
        chk("rst_done", {63'h0, done_o}, 64'h0);
        chk("rst_hi",   {32'h0, hi_o}, 64'h0);
        chk("rst_lo",   {32'h0, lo_o}, 64'h0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // MTHI in IDLE: immediate write, never busy.
        issue(F_MTHI, 32'h12345678, 32'h0);
        chk("mthi_hi",   {32'h0, hi_o}, 64'h12345678);
        chk("mthi_busy", {63'h0, busy_o}, 64'h0);
        chk("mthi_lo",   {32'h0, lo_o}, 64'h0);

        // Non HI/LO funct is ignored.
        issue(F_ADD, 32'hAAAA5555, 32'h11111111);
        chk("add_busy", {63'h0, busy_o}, 64'h0);
        chk("add_hi",   {32'h0, hi_o}, 64'h12345678);
        chk("add_lo",   {32'h0, lo_o}, 64'h0);

        issue(F_MTLO, 32'hCAFEF00D, 32'h0);
        chk("mtlo_lo", {32'h0, lo_o}, 64'hCAFEF00D);

        // MULTU max x max with exact busy/done timing.
        sb.push_back({32'hFFFFFFFE, 32'h00000001});
        issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        busy_cnt = 0;
        done_at  = 0;
        for (int j = 1; j <= 40; j++) begin
            if (busy_o) busy_cnt++;
            if (done_o) done_at = j;
            @(negedge clk_i);
        end
        chk("multu_busy_cycles", 64'(busy_cnt), 64'd33);
        chk("multu_done_cycle",  64'(done_at),  64'd33);

        sb.push_back({32'hFFFFFFFF, 32'hFFFFFFF1});
        issue(F_MULT, 32'hFFFFFFFD, 32'h00000005);
        wait_idle();

        sb.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
        issue(F_DIV, 32'hFFFFFFF9, 32'h00000002);
        wait_idle();

        sb.push_back({32'h00000007, 32'hFFFFFFFF});
        issue(F_DIVU, 32'h00000007, 32'h00000000);
        wait_idle();

        sb.push_back({32'hFFFFFFF9, 32'hFFFFFFFF});
        issue(F_DIV, 32'hFFFFFFF9, 32'h00000000);
        wait_idle();

        sb.push_back({32'h00000000, 32'h80000000});
        issue(F_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();

        // MTLO during a DIVU run is dropped.
        sb.push_back({32'h00000002, 32'h0000000E});
        issue(F_DIVU, 32'd100, 32'd7);
        repeat (4) @(negedge clk_i);
        issue(F_MTLO, 32'h0000DEAD, 32'h0);
        wait_idle();
        chk("mtlo_ignored_lo", {32'h0, lo_o}, 64'h0000000E);

        // Operand change plus a second start mid-run do not disturb the result.
        sb.push_back({32'h00000000, 32'h0000000C});
        issue(F_MULTU, 32'd3, 32'd4);
        repeat (9) @(negedge clk_i);
        issue(F_DIVU, 32'd99, 32'd7);
        src1_i = 32'h55555555;
        src2_i = 32'h33333333;
        wait_idle();

        // Reset at RUN cycle 20 aborts with no done_o.
        issue(F_MULTU, 32'd5, 32'd6);
        repeat (19) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("abort_busy", {63'h0, busy_o}, 64'h0);
        chk("abort_hi",   {32'h0, hi_o}, 64'h0);
        chk("abort_lo",   {32'h0, lo_o}, 64'h0);
        rst_i = 1'b0;
        repeat (40) @(negedge clk_i);

        chk("scoreboard_drained", 64'(sb.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
